// File: rtl/sandpile_pkg.sv
// rtl/sandpile_pkg.sv - shared owner/state types and cell width for the grid port arbiter
package sandpile_pkg;

  localparam int CELL_W = 3;

  // Which requester drove the RAM for a read in the previous cycle
  typedef enum logic [1:0] {
    OWN_NONE,
    OWN_REND,
    OWN_SPI,
    OWN_SIM
  } owner_e;

  // LOCKED keeps the SPI readback out while the simulation does read-modify-write
  typedef enum logic {
    ST_IDLE,
    ST_LOCKED
  } state_e;

endpackage

// File: rtl/grid_port_arbiter_if.sv
// rtl/grid_port_arbiter_if.sv - request/response and RAM port bundle of the grid port arbiter
interface grid_port_arbiter_if import sandpile_pkg::*; #(
  parameter int ROWS = 32,
  parameter int COLS = 32
);

  localparam int XW = $clog2(ROWS);
  localparam int YW = $clog2(COLS);

  logic              r_req;
  logic [XW-1:0]     r_x;
  logic [YW-1:0]     r_y;
  logic              r_rvalid;

  logic              s_req;
  logic [XW-1:0]     s_x;
  logic [YW-1:0]     s_y;
  logic              s_gnt;
  logic              s_rvalid;

  logic              m_req;
  logic              m_we;
  logic              m_lock;
  logic [XW-1:0]     m_x;
  logic [YW-1:0]     m_y;
  logic [CELL_W-1:0] m_wdata;
  logic              m_gnt;
  logic              m_rvalid;

  logic [CELL_W-1:0] rdata;

  logic              mem_en;
  logic              mem_we;
  logic [XW-1:0]     mem_x;
  logic [YW-1:0]     mem_y;
  logic [CELL_W-1:0] mem_wdata;
  logic [CELL_W-1:0] mem_rdata;

  logic              starve;

  modport slave (
    input  r_req, r_x, r_y, s_req, s_x, s_y,
    input  m_req, m_we, m_lock, m_x, m_y, m_wdata, mem_rdata,
    output r_rvalid, s_gnt, s_rvalid, m_gnt, m_rvalid, rdata,
    output mem_en, mem_we, mem_x, mem_y, mem_wdata, starve
  );

  modport master (
    output r_req, r_x, r_y, s_req, s_x, s_y,
    output m_req, m_we, m_lock, m_x, m_y, m_wdata, mem_rdata,
    input  r_rvalid, s_gnt, s_rvalid, m_gnt, m_rvalid, rdata,
    input  mem_en, mem_we, mem_x, mem_y, mem_wdata, starve
  );

endinterface

// File: rtl/rr_pick2.sv
// rtl/rr_pick2.sv - two-requester round-robin picker (bit 0 = SIM, bit 1 = SPI)
module rr_pick2 (
  input  logic [1:0] req,
  input  logic       last,
  output logic [1:0] gnt
);

  // On contention the requester that did not win last time goes first
  always_comb begin
    gnt = req;
    if (req == 2'b11) begin
      gnt = last ? 2'b01 : 2'b10;
    end
  end

endmodule

// File: rtl/grid_port_arbiter.sv
// rtl/grid_port_arbiter.sv - single-port grid RAM arbiter for renderer, SPI readback and simulation
module grid_port_arbiter import sandpile_pkg::*; #(
  parameter int ROWS       = 32,
  parameter int COLS       = 32,
  parameter int STARVE_MAX = 64
) (
  input logic                clk,
  input logic                rst,
  grid_port_arbiter_if.slave bus
);

  localparam int XW = $clog2(ROWS);
  localparam int YW = $clog2(COLS);

  state_e            state_q, state_d;
  owner_e            owner_q, owner_d;
  logic              last_s_q;
  logic [7:0]        wait_q, wait_d;
  logic              starve_q;

  logic [1:0]        pick_req, pick_gnt;
  logic              gnt_s, gnt_m;
  logic              en_d, we_d;
  logic [XW-1:0]     x_d;
  logic [YW-1:0]     y_d;
  logic [CELL_W-1:0] wdata_d;

  // The renderer (and reset) take the port away from S and M outright
  assign pick_req = (rst || bus.r_req) ? 2'b00
                  : {bus.s_req && (state_q != ST_LOCKED), bus.m_req};

  rr_pick2 u_pick (
    .req  (pick_req),
    .last (last_s_q),
    .gnt  (pick_gnt)
  );

  assign gnt_m = pick_gnt[0];
  assign gnt_s = pick_gnt[1];

  // Port mux, read-owner selection and lock state transitions
  always_comb begin
    en_d    = 1'b0;
    we_d    = 1'b0;
    x_d     = '0;
    y_d     = '0;
    wdata_d = '0;
    owner_d = OWN_NONE;
    state_d = state_q;

    if (!rst && bus.r_req) begin
      en_d    = 1'b1;
      x_d     = bus.r_x;
      y_d     = bus.r_y;
      owner_d = OWN_REND;
    end else if (gnt_m) begin
      en_d    = 1'b1;
      we_d    = bus.m_we;
      x_d     = bus.m_x;
      y_d     = bus.m_y;
      wdata_d = bus.m_wdata;
      owner_d = bus.m_we ? OWN_NONE : OWN_SIM;
    end else if (gnt_s) begin
      en_d    = 1'b1;
      x_d     = bus.s_x;
      y_d     = bus.s_y;
      owner_d = OWN_SPI;
    end

    case (state_q)
      ST_IDLE: begin
        if (gnt_m && !bus.m_we && bus.m_lock) state_d = ST_LOCKED;
      end
      ST_LOCKED: begin
        if ((gnt_m && bus.m_we) || !bus.m_req) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign wait_d = (gnt_s || gnt_m)                           ? 8'd0
                : ((bus.s_req || bus.m_req) && wait_q != 8'hFF) ? wait_q + 8'd1
                : wait_q;

  // State register, fairness pointer, read-owner tag, wait counter and sticky starve flag
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      owner_q  <= OWN_NONE;
      last_s_q <= 1'b1;
      wait_q   <= 8'd0;
      starve_q <= 1'b0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      if (gnt_m)      last_s_q <= 1'b0;
      else if (gnt_s) last_s_q <= 1'b1;
      wait_q <= wait_d;
      if (wait_d == 8'(STARVE_MAX)) starve_q <= 1'b1;
    end
  end

  assign bus.mem_en    = en_d;
  assign bus.mem_we    = we_d;
  assign bus.mem_x     = x_d;
  assign bus.mem_y     = y_d;
  assign bus.mem_wdata = wdata_d;
  assign bus.s_gnt     = gnt_s;
  assign bus.m_gnt     = gnt_m;
  assign bus.r_rvalid  = (owner_q == OWN_REND);
  assign bus.s_rvalid  = (owner_q == OWN_SPI);
  assign bus.m_rvalid  = (owner_q == OWN_SIM);
  assign bus.rdata     = bus.mem_rdata;
  assign bus.starve    = starve_q;

endmodule

// File: tb/tb_grid_port_arbiter.sv
// tb/tb_grid_port_arbiter.sv - self-checking bench for grid_port_arbiter
module tb_grid_port_arbiter;

  localparam int ROWS = 32;
  localparam int COLS = 32;
  localparam int SMAX = 64;

  logic clk;
  logic rst;
  int   n_tests;
  int   n_fail;

  grid_port_arbiter_if #(.ROWS(ROWS), .COLS(COLS)) bus ();

  grid_port_arbiter #(.ROWS(ROWS), .COLS(COLS), .STARVE_MAX(SMAX)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic r, s, m, we, lock;
    logic en, mwe, sg, mg;
    int   x;
  } vec_t;

  vec_t vt[8];

  // reference model: pending read owner 0 none,1 R,2 S,3 M
  int md_locked, md_last_s, md_pend, md_wait, md_starve;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic to_neg;
    @(negedge clk);
  endtask

  task automatic clear_in;
    bus.r_req = 0; bus.r_x = '0; bus.r_y = '0;
    bus.s_req = 0; bus.s_x = '0; bus.s_y = '0;
    bus.m_req = 0; bus.m_we = 0; bus.m_lock = 0;
    bus.m_x = '0; bus.m_y = '0; bus.m_wdata = '0;
    bus.mem_rdata = '0;
  endtask

  task automatic do_reset;
    clear_in();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    md_locked = 0; md_last_s = 1; md_pend = 0; md_wait = 0; md_starve = 0;
  endtask

  task automatic set_ops;
    bus.r_x = 5'd1; bus.r_y = 5'd11;
    bus.s_x = 5'd2; bus.s_y = 5'd12;
    bus.m_x = 5'd3; bus.m_y = 5'd13;
    bus.m_wdata = 3'd6;
  endtask

  // one random cycle: compare DUT against the model, then advance the model
  task automatic rand_cycle;
    int win, s_ok, xe, ye;
    bus.r_req  = ($urandom_range(0, 9) < 3);
    bus.s_req  = $urandom_range(0, 1) == 1;
    bus.m_req  = $urandom_range(0, 1) == 1;
    bus.m_we   = ($urandom_range(0, 9) < 4);
    bus.m_lock = $urandom_range(0, 1) == 1;
    bus.r_x = 5'($urandom); bus.r_y = 5'($urandom);
    bus.s_x = 5'($urandom); bus.s_y = 5'($urandom);
    bus.m_x = 5'($urandom); bus.m_y = 5'($urandom);
    bus.m_wdata   = 3'($urandom);
    bus.mem_rdata = 3'($urandom);
    to_neg();

    s_ok = (bus.s_req && !md_locked) ? 1 : 0;
    if (bus.r_req)                   win = 1;
    else if (bus.m_req && s_ok != 0) win = md_last_s ? 3 : 2;
    else if (bus.m_req)              win = 3;
    else if (s_ok != 0)              win = 2;
    else                             win = 0;

    xe = (win == 1) ? int'(bus.r_x) : (win == 2) ? int'(bus.s_x) : (win == 3) ? int'(bus.m_x) : 0;
    ye = (win == 1) ? int'(bus.r_y) : (win == 2) ? int'(bus.s_y) : (win == 3) ? int'(bus.m_y) : 0;

    chk("rnd_mem_en", 32'(bus.mem_en), 32'(win != 0));
    chk("rnd_mem_we", 32'(bus.mem_we), 32'(win == 3 && bus.m_we));
    chk("rnd_mem_x",  32'(bus.mem_x), 32'(xe));
    chk("rnd_mem_y",  32'(bus.mem_y), 32'(ye));
    chk("rnd_s_gnt",  32'(bus.s_gnt), 32'(win == 2));
    chk("rnd_m_gnt",  32'(bus.m_gnt), 32'(win == 3));
    if (win == 3 && bus.m_we) chk("rnd_wdata", 32'(bus.mem_wdata), 32'(bus.m_wdata));
    chk("rnd_r_rvalid", 32'(bus.r_rvalid), 32'(md_pend == 1));
    chk("rnd_s_rvalid", 32'(bus.s_rvalid), 32'(md_pend == 2));
    chk("rnd_m_rvalid", 32'(bus.m_rvalid), 32'(md_pend == 3));
    if (md_pend != 0) chk("rnd_rdata", 32'(bus.rdata), 32'(bus.mem_rdata));
    chk("rnd_starve", 32'(bus.starve), 32'(md_starve));

    if (!md_locked && win == 3 && !bus.m_we && bus.m_lock) md_locked = 1;
    else if (md_locked && ((win == 3 && bus.m_we) || !bus.m_req)) md_locked = 0;
    md_pend = (win == 1 || win == 2 || (win == 3 && !bus.m_we)) ? win : 0;
    if (win == 3) md_last_s = 0;
    if (win == 2) md_last_s = 1;
    if (win == 2 || win == 3) md_wait = 0;
    else if ((bus.s_req || bus.m_req) && md_wait < 255) md_wait++;
    if (md_wait == SMAX) md_starve = 1;
    tick();
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    rst     = 1'b1;
    clear_in();

    vt[0] = '{0,0,0,0,0, 0,0,0,0, 0};
    vt[1] = '{1,0,0,0,0, 1,0,0,0, 1};
    vt[2] = '{0,1,0,0,0, 1,0,1,0, 2};
    vt[3] = '{0,0,1,0,0, 1,0,0,1, 3};
    vt[4] = '{0,0,1,1,0, 1,1,0,1, 3};
    vt[5] = '{0,1,1,0,0, 1,0,0,1, 3};
    vt[6] = '{1,1,1,0,0, 1,0,0,0, 1};
    vt[7] = '{1,0,1,1,1, 1,0,0,0, 1};

    // outputs held quiet under reset even with every request raised
    tick();
    set_ops();
    bus.r_req = 1; bus.s_req = 1; bus.m_req = 1;
    to_neg();
    chk("rst_mem_en", 32'(bus.mem_en), 0);
    chk("rst_gnts",   32'({bus.s_gnt, bus.m_gnt}), 0);
    chk("rst_rvalid", 32'({bus.r_rvalid, bus.s_rvalid, bus.m_rvalid}), 0);
    chk("rst_mem_x",  32'(bus.mem_x), 0);
    chk("rst_starve", 32'(bus.starve), 0);

    // single-cycle arbitration table, each from a fresh reset
    for (int i = 0; i < 8; i++) begin
      do_reset();
      set_ops();
      bus.r_req = vt[i].r; bus.s_req = vt[i].s; bus.m_req = vt[i].m;
      bus.m_we = vt[i].we; bus.m_lock = vt[i].lock;
      to_neg();
      chk($sformatf("vec%0d_en", i),  32'(bus.mem_en), 32'(vt[i].en));
      chk($sformatf("vec%0d_we", i),  32'(bus.mem_we), 32'(vt[i].mwe));
      chk($sformatf("vec%0d_sg", i),  32'(bus.s_gnt),  32'(vt[i].sg));
      chk($sformatf("vec%0d_mg", i),  32'(bus.m_gnt),  32'(vt[i].mg));
      chk($sformatf("vec%0d_x", i),   32'(bus.mem_x),  32'(vt[i].x));
    end

    // renderer read at (5,7) with data 3
    do_reset();
    bus.r_req = 1; bus.r_x = 5'd5; bus.r_y = 5'd7;
    to_neg();
    chk("rend_mem_x", 32'(bus.mem_x), 5);
    chk("rend_mem_y", 32'(bus.mem_y), 7);
    tick();
    bus.r_req = 0; bus.mem_rdata = 3'd3;
    to_neg();
    chk("rend_rvalid", 32'(bus.r_rvalid), 1);
    chk("rend_rdata",  32'(bus.rdata), 3);

    // S and M contending alternate M,S,M,S with rvalid one cycle behind
    do_reset();
    set_ops();
    bus.s_req = 1; bus.m_req = 1;
    for (int i = 0; i < 5; i++) begin
      to_neg();
      if (i < 4) begin
        chk($sformatf("rr%0d_m_gnt", i), 32'(bus.m_gnt), 32'(i % 2 == 0));
        chk($sformatf("rr%0d_s_gnt", i), 32'(bus.s_gnt), 32'(i % 2 == 1));
      end
      if (i > 0) begin
        chk($sformatf("rr%0d_m_rv", i), 32'(bus.m_rvalid), 32'(i % 2 == 1));
        chk($sformatf("rr%0d_s_rv", i), 32'(bus.s_rvalid), 32'(i % 2 == 0));
      end
      tick();
    end

    // locked read-modify-write keeps S out until the write
    do_reset();
    set_ops();
    bus.m_req = 1; bus.m_lock = 1;
    to_neg();
    chk("lock_rd_gnt", 32'(bus.m_gnt), 1);
    tick();
    bus.s_req = 1;
    to_neg();
    chk("lock_hold_m", 32'(bus.m_gnt), 1);
    chk("lock_hold_s", 32'(bus.s_gnt), 0);
    tick();
    bus.m_we = 1; bus.m_lock = 0; bus.m_wdata = 3'd4;
    to_neg();
    chk("lock_wr_mgnt",  32'(bus.m_gnt), 1);
    chk("lock_wr_sgnt",  32'(bus.s_gnt), 0);
    chk("lock_wr_we",    32'(bus.mem_we), 1);
    chk("lock_wr_wdata", 32'(bus.mem_wdata), 4);
    tick();
    bus.m_req = 0; bus.m_we = 0;
    to_neg();
    chk("lock_after_s", 32'(bus.s_gnt), 1);
    chk("lock_after_m_rv", 32'(bus.m_rvalid), 0);

    // starvation under a 64-cycle renderer hog
    do_reset();
    set_ops();
    bus.r_req = 1; bus.s_req = 1;
    repeat (63) tick();
    to_neg();
    chk("starve_63", 32'(bus.starve), 0);
    chk("starve_sgnt_blocked", 32'(bus.s_gnt), 0);
    tick();
    to_neg();
    chk("starve_64", 32'(bus.starve), 1);
    tick();
    bus.r_req = 0;
    to_neg();
    chk("starve_sgnt", 32'(bus.s_gnt), 1);
    tick();
    bus.s_req = 0;
    to_neg();
    chk("starve_sticky", 32'(bus.starve), 1);
    chk("starve_s_rv",   32'(bus.s_rvalid), 1);

    // reset in the middle of a read
    do_reset();
    set_ops();
    bus.m_req = 1; bus.s_req = 1;
    to_neg();
    chk("mid_m_gnt", 32'(bus.m_gnt), 1);
    tick();
    chk("mid_m_rv_pre", 32'(bus.m_rvalid), 1);
    rst = 1'b1;
    #1;
    chk("mid_rst_m_rv", 32'(bus.m_rvalid), 0);
    chk("mid_rst_gnts", 32'({bus.s_gnt, bus.m_gnt}), 0);
    chk("mid_rst_en",   32'(bus.mem_en), 0);
    tick();
    rst = 1'b0;
    to_neg();
    chk("post_rst_m_gnt", 32'(bus.m_gnt), 1);
    chk("post_rst_s_gnt", 32'(bus.s_gnt), 0);
    chk("post_rst_rv",    32'({bus.s_rvalid, bus.m_rvalid}), 0);

    // randomized traffic against the model
    do_reset();
    for (int i = 0; i < 400; i++) rand_cycle();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/grid_port_arbiter.md
GRID_PORT_ARBITER -- requirements
Module: grid_port_arbiter

Interface
REQ-001 Parameter ROWS, default 32: grid rows; X address width XW = clog2(ROWS).
REQ-002 Parameter COLS, default 32: grid columns; Y address width YW = clog2(COLS).
REQ-003 Parameter STARVE_MAX, default 64: pending-cycle threshold for the starvation flag, range 1..255.
REQ-004 clk  in  1  single system clock; all logic is on its rising edge.
REQ-005 rst  in  1  asynchronous, active-high reset.
REQ-006 r_req, r_x[XW], r_y[YW]  in  renderer read request.
REQ-007 r_rvalid  out  1  renderer read data valid.
REQ-008 s_req, s_x[XW], s_y[YW]  in  SPI readback read request.
REQ-009 s_gnt, s_rvalid  out  1 each  SPI grant and read data valid.
REQ-010 m_req, m_we, m_lock, m_x[XW], m_y[YW], m_wdata[3]  in  simulation read/write request.
REQ-011 m_gnt, m_rvalid  out  1 each  simulation grant and read data valid.
REQ-012 rdata[3]  out  shared read data, qualified by the *_rvalid signals.
REQ-013 mem_en, mem_we, mem_x[XW], mem_y[YW], mem_wdata[3]  out  single-port grid RAM port.
REQ-014 mem_rdata[3]  in  RAM read data, valid 1 cycle after mem_en with mem_we=0.
REQ-015 starve  out  1  sticky starvation flag.

Function
REQ-016 Port arbitration shall be combinational in the request cycle; exactly one requester owns mem_* per cycle.
REQ-017 Renderer priority is absolute: r_req=1 drives mem_* from r_x/r_y with mem_we=0 in the same cycle; r_req has no grant signal.
REQ-018 With r_req=0, S and M arbitrate round-robin; a 1-bit last-winner pointer updates on every S or M grant.
REQ-019 Tie-break after reset: M wins first.
REQ-020 s_gnt and m_gnt are single-cycle pulses in the cycle the RAM is driven; a requester holds req and operands until it is granted.
REQ-021 A read is granted when we=0. rdata = mem_rdata, and the owner's rvalid rises exactly 1 cycle after the grant; routing uses a registered owner tag.
REQ-022 A write is granted when m_we=1. mem_wdata = m_wdata, and no rvalid is produced.
REQ-023 FSM states: IDLE and LOCKED. IDLE to LOCKED on an M read grant with m_lock=1.
REQ-024 LOCKED blocks S; R still preempts. LOCKED returns to IDLE on an M write grant or when m_req drops.
REQ-025 Idle port (no requests): mem_en=0 and all grants are 0.
REQ-026 Wait counter: 8 bits, saturating at 255. It increments each cycle s_req or m_req is pending but ungranted, and clears on any S or M grant.
REQ-027 starve is set when the wait counter reaches STARVE_MAX; it is cleared only by rst.
REQ-028 S and M requests arriving simultaneously with r_req: both wait; neither grant is asserted.

Reset
REQ-029 rst clears: FSM to IDLE, pointer to M-first, owner tag to none, wait counter to 0, starve to 0.
REQ-030 rst forces all *_gnt, *_rvalid and mem_en to 0; mem_x, mem_y and mem_wdata reset to 0.
REQ-031 A read granted in the cycle rst asserts shall produce no rvalid after rst deasserts.

Structure
REQ-032 Shared package sandpile_pkg holds: owner enum (NONE, REND, SPI, SIM), the FSM state enum, and the cell width constant (3).
REQ-033 One sub-module, rr_pick2: a two-requester round-robin picker with a pointer input and a grant output.

Verification
REQ-034 r_req=1 at (5,7), mem_rdata=3 -> mem_x=5, mem_y=7 in the same cycle; r_rvalid=1 and rdata=3 one cycle later.
REQ-035 s_req and m_req (read) held together, r_req=0 -> grants alternate M,S,M,S over 4 cycles; each rvalid follows its grant by 1 cycle.
REQ-036 m_req read with m_lock=1, then s_req plus m_req write with wdata=4 -> m_gnt on the write, mem_we=1, mem_wdata=4; s_gnt only after that.
REQ-037 r_req held 64 cycles with s_req pending, STARVE_MAX=64 -> starve=1 at cycle 64 and remains 1 after s_gnt.
REQ-038 rst asserted mid-read -> all rvalid and grants go to 0 within the cycle; first post-reset contention grants M.
